// File: rtl/serializer.sv
// Byte FIFO feeding an MSB-first serial transmitter, paced by the receiver's
// availability flag so an unconsumed byte is never overrun.
module serializer #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk_100mhz,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       write_in,
    input  logic       status_in,
    output logic       data_out,
    output logic       write_out,
    output logic       status_out,
    output logic       busy,
    output logic       byte_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_next;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_next;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;
    logic            push, pop;

    // status_out is the registered not-full flag, so a push against a full
    // FIFO is rejected even if a pop frees a slot on the same edge.
    assign push = write_in && status_out;
    assign busy = (state != IDLE);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        write_out  = 1'b0;
        data_out   = 1'b0;
        byte_done  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && status_in) begin
                    pop        = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                write_out = 1'b1;
                data_out  = shreg[7];
                if (bit_cnt == 3'd7) begin
                    byte_done  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!status_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            status_out <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= '0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            status_out <= (count_next != FULL);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                shreg   <= mem[rd_ptr];
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: behavioural receiver reassembles bytes,
// hand-computed expectations for bit order, handshake and FIFO behaviour.
module tb_serializer;

    logic       clk_100mhz = 1'b0;
    logic       reset      = 1'b0;
    logic [7:0] data_in    = '0;
    logic       write_in   = 1'b0;
    logic       status_in  = 1'b0;
    logic       data_out, write_out, status_out, busy, byte_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] rx_sh    = '0;
    int         rx_n     = 0;
    int         done_cnt = 0;

    serializer #(.FIFO_DEPTH(2)) dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .data_in    (data_in),
        .write_in   (write_in),
        .status_in  (status_in),
        .data_out   (data_out),
        .write_out  (write_out),
        .status_out (status_out),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Receiver model: left-shifts valid bits, one byte per 8 strobes.
    always @(negedge clk_100mhz) begin
        if (!reset) begin
            rx_n = 0;
        end else begin
            if (byte_done) done_cnt++;
            if (write_out) begin
                rx_sh = {rx_sh[6:0], data_out};
                if (rx_n == 7) begin
                    rx_q.push_back(rx_sh);
                    rx_n = 0;
                end else begin
                    rx_n++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk_100mhz);
        data_in  = b;
        write_in = 1'b1;
        @(negedge clk_100mhz);
        write_in = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_100mhz);
            seen = byte_done;
        end
        check(tag, seen, 1'b1);
    endtask

    task automatic handshake();
        @(negedge clk_100mhz);
        status_in = 1'b0;
        @(negedge clk_100mhz);
        status_in = 1'b1;
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] b);
        logic [7:0] got;
        got = 8'hxx;
        if (rx_q.size() != 0) got = rx_q.pop_front();
        check(tag, got, b);
    endtask

    task automatic expect_bits(input string tag, input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_100mhz);
            check({tag, "_wr"}, write_out, 1'b1);
            check({tag, "_bit"}, data_out, b[7-i]);
            check({tag, "_done"}, byte_done, (i == 7));
        end
    endtask

    initial begin
        int bad;
        int d0;

        // Reset
        repeat (3) @(negedge clk_100mhz);
        reset = 1'b1;
        @(negedge clk_100mhz);
        check("rst_status", status_out, 1'b1);
        check("rst_wr", write_out, 1'b0);
        check("rst_data", data_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", byte_done, 1'b0);

        // Single byte
        status_in = 1'b1;
        d0 = done_cnt;
        push_byte(8'hA5);
        expect_bits("a5", 8'hA5);
        @(negedge clk_100mhz);
        check("a5_after_wr", write_out, 1'b0);
        check("a5_after_busy", busy, 1'b1);
        expect_rx("a5_rx", 8'hA5);
        check("a5_pulses", done_cnt - d0, 1);
        handshake();

        // Back-to-back with handshake
        rx_q.delete();
        push_byte(8'h3C);
        push_byte(8'hC3);
        wait_done("b2b_done1");
        @(negedge clk_100mhz);
        status_in = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk_100mhz);
            if (write_out) bad++;
        end
        check("b2b_quiet", bad, 0);
        status_in = 1'b1;
        @(negedge clk_100mhz);
        check("b2b_start_wr", write_out, 1'b1);
        check("b2b_start_bit", data_out, 1'b1);
        wait_done("b2b_done2");
        @(negedge clk_100mhz);
        expect_rx("b2b_rx1", 8'h3C);
        expect_rx("b2b_rx2", 8'hC3);

        // FIFO full
        rx_q.delete();
        status_in = 1'b0;
        push_byte(8'h11);
        check("full_st1", status_out, 1'b1);
        push_byte(8'h22);
        check("full_st2", status_out, 1'b0);
        push_byte(8'h33);
        check("full_st3", status_out, 1'b0);
        check("full_idle_wr", write_out, 1'b0);
        status_in = 1'b1;
        @(negedge clk_100mhz);
        check("full_pop_st", status_out, 1'b1);
        check("full_pop_wr", write_out, 1'b1);
        wait_done("full_done1");
        handshake();
        wait_done("full_done2");
        handshake();
        repeat (12) @(negedge clk_100mhz);
        expect_rx("full_rx1", 8'h11);
        expect_rx("full_rx2", 8'h22);
        check("full_rx_cnt", rx_q.size(), 0);

        // Receiver busy
        status_in = 1'b0;
        push_byte(8'h55);
        bad = 0;
        repeat (20) begin
            @(negedge clk_100mhz);
            if (write_out || busy) bad++;
        end
        check("stall_quiet", bad, 0);
        status_in = 1'b1;
        @(negedge clk_100mhz);
        check("stall_start", write_out, 1'b1);
        wait_done("stall_done");
        @(negedge clk_100mhz);
        expect_rx("stall_rx", 8'h55);
        handshake();

        // Reset mid-byte with a second byte queued
        rx_q.delete();
        push_byte(8'hFF);
        push_byte(8'h77);
        repeat (2) @(negedge clk_100mhz);
        reset = 1'b0;
        #1;
        check("mrst_wr", write_out, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_status", status_out, 1'b1);
        repeat (2) @(negedge clk_100mhz);
        reset = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk_100mhz);
            if (write_out) bad++;
        end
        check("mrst_empty", bad, 0);
        check("mrst_rx_none", rx_q.size(), 0);
        push_byte(8'h81);
        expect_bits("r81", 8'h81);
        @(negedge clk_100mhz);
        expect_rx("r81_rx", 8'h81);
        check("r81_rx_cnt", rx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
